// File: rtl/ysyx_24080014_pkg.sv
// Shared encodings for the load/store unit: access sizes,
// AXI response codes and the LSU state machine states.
package ysyx_24080014_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } lsu_state_e;

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// Byte-lane steering: store strobe/data placement and
// load extraction with zero or sign extension.
module ysyx_24080014_lsu_align
  import ysyx_24080014_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [1:0]          size,
  input  logic [OFF_W-1:0]    off,
  input  logic                sign,
  input  logic [DATA_W-1:0]   st_data,
  output logic [DATA_W/8-1:0] st_strb,
  output logic [DATA_W-1:0]   st_lane,
  input  logic [DATA_W-1:0]   ld_lane,
  output logic [DATA_W-1:0]   ld_data
);

  localparam int NB = DATA_W/8;

  logic [NB-1:0]     base;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              msb;
  int                nbits;

  always_comb begin
    case (size)
      SZ_B:    base = NB'(1);
      SZ_H:    base = NB'(3);
      SZ_W:    base = NB'(15);
      default: base = '1;
    endcase
    st_strb = base << off;
    st_lane = st_data << {off, 3'b000};
    shifted = ld_lane >> {off, 3'b000};
    nbits = 8 << size;
    if (nbits > DATA_W) nbits = DATA_W;
    // all-ones shifted down leaves exactly nbits of ones
    mask = {DATA_W{1'b1}} >> (DATA_W - nbits);
    msb = shifted[nbits-1];
    ld_data = shifted & mask;
    if (sign && msb) ld_data = ld_data | ~mask;
  end

endmodule

// File: rtl/ysyx_24080014_lsu_axi.sv
// Load/store unit: one core request at a time translated
// into a single AXI4-lite read or write transaction.
module ysyx_24080014_lsu_axi
  import ysyx_24080014_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);

  lsu_state_e        state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [DATA_W-1:0] r_wdata;
  logic              aw_done;
  logic              w_done;
  logic              aw_hs;
  logic              w_hs;
  logic [OFF_W-1:0]  amask;
  logic              misal;
  logic [DATA_W-1:0] ld_data;

  assign req_ready = (state == IDLE);
  assign araddr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign awaddr = araddr;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;

  always_comb begin
    case (req_size)
      SZ_B:    amask = '0;
      SZ_H:    amask = OFF_W'(1);
      SZ_W:    amask = OFF_W'(3);
      default: amask = OFF_W'(7);
    endcase
    // a dword never fits a 32-bit bus
    misal = (|(req_addr[OFF_W-1:0] & amask)) ||
            ((req_size == SZ_D) && (DATA_W < 64));
  end

  ysyx_24080014_lsu_align #(
    .DATA_W(DATA_W),
    .OFF_W (OFF_W)
  ) u_align (
    .size   (r_size),
    .off    (r_addr[OFF_W-1:0]),
    .sign   (r_sign),
    .st_data(r_wdata),
    .st_strb(wstrb),
    .st_lane(wdata),
    .ld_lane(rdata),
    .ld_data(ld_data)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      arvalid   <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      rready    <= 1'b0;
      bready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_size    <= SZ_B;
      r_sign    <= 1'b0;
      r_wdata   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_addr  <= req_addr;
          r_size  <= req_size;
          r_sign  <= req_sign;
          r_wdata <= req_wdata;
          if (misal) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RSP;
          end else if (req_we) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR;
          end else begin
            arvalid <= 1'b1;
            state   <= RD_ADDR;
          end
        end
        RD_ADDR: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= RD_DATA;
        end
        RD_DATA: if (rvalid) begin
          rready    <= 1'b0;
          rsp_rdata <= ld_data;
          rsp_err   <= (rresp != OKAY);
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        WR: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: if (bvalid) begin
          bready    <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= (bresp != OKAY);
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused;
  assign unused = r_we;

endmodule

// File: tb/tb_ysyx_24080014_lsu_axi.sv
// Directed bench for the LSU: the AXI slave is played by hand,
// one step per falling edge, with fixed cycle counts.
module tb_ysyx_24080014_lsu_axi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 0, req_we = 0, req_sign = 0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        rsp_valid, rsp_err;
  logic        rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, araddr, wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 0, wready = 0, bvalid = 0;
  logic        arready = 0, rvalid = 0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  int vectors = 0;
  int errs = 0;
  int ar_cnt = 0;
  int b_cnt = 0;
  int ar0, b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arvalid) ar_cnt <= ar_cnt + 1;
    if (bvalid && bready) b_cnt <= b_cnt + 1;
  end

  ysyx_24080014_lsu_axi dut (
    .aclk(clk), .aresetn(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_sign(req_sign),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] wd);
    req_we = we; req_addr = a; req_size = sz;
    req_sign = sg; req_wdata = wd; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    step();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // lb signed, offset 3
    issue(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'd0);
    chk("lb_arvalid", {31'd0, arvalid}, 32'd1);
    chk("lb_araddr", araddr, 32'h8000_0000);
    chk("lb_req_ready", {31'd0, req_ready}, 32'd0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("lb_ar_drop", {31'd0, arvalid}, 32'd0);
    chk("lb_rready", {31'd0, rready}, 32'd1);
    rvalid = 1'b1; rdata = 32'h80FF_FFFF; rresp = 2'd0;
    step();
    rvalid = 1'b0;
    chk("lb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
    chk("lb_err", {31'd0, rsp_err}, 32'd0);
    chk("lb_rready_low", {31'd0, rready}, 32'd0);
    finish_rsp();
    chk("lb_idle", {31'd0, req_ready}, 32'd1);

    // sh at offset 2, both channels ready together
    issue(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_BEEF);
    chk("sh_awvalid", {31'd0, awvalid}, 32'd1);
    chk("sh_wvalid", {31'd0, wvalid}, 32'd1);
    chk("sh_awaddr", awaddr, 32'h8000_0000);
    chk("sh_wdata", wdata, 32'hBEEF_0000);
    chk("sh_wstrb", {28'd0, wstrb}, 32'hC);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    chk("sh_aw_drop", {31'd0, awvalid}, 32'd0);
    chk("sh_w_drop", {31'd0, wvalid}, 32'd0);
    chk("sh_bready", {31'd0, bready}, 32'd1);
    bvalid = 1'b1; bresp = 2'd0;
    step();
    bvalid = 1'b0;
    chk("sh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sh_err", {31'd0, rsp_err}, 32'd0);
    chk("sh_rdata", rsp_rdata, 32'd0);
    finish_rsp();

    // misaligned lw
    ar0 = ar_cnt;
    issue(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'd0);
    chk("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mis_err", {31'd0, rsp_err}, 32'd1);
    chk("mis_rdata", rsp_rdata, 32'd0);
    finish_rsp();
    chk("mis_no_ar", ar_cnt - ar0, 32'd0);

    // sw, W accepted two cycles before AW
    b0 = b_cnt;
    issue(1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'h1234_5678);
    chk("sw_wstrb", {28'd0, wstrb}, 32'hF);
    chk("sw_wdata", wdata, 32'h1234_5678);
    wready = 1'b1;
    step();
    wready = 1'b0;
    chk("sw_w_drop", {31'd0, wvalid}, 32'd0);
    chk("sw_aw_hold", {31'd0, awvalid}, 32'd1);
    chk("sw_no_bready", {31'd0, bready}, 32'd0);
    step();
    chk("sw_aw_hold2", {31'd0, awvalid}, 32'd1);
    chk("sw_awaddr", awaddr, 32'h8000_0010);
    chk("sw_w_still_low", {31'd0, wvalid}, 32'd0);
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("sw_aw_drop", {31'd0, awvalid}, 32'd0);
    chk("sw_bready", {31'd0, bready}, 32'd1);
    bvalid = 1'b1; bresp = 2'd0;
    step();
    chk("sw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sw_bready_low", {31'd0, bready}, 32'd0);
    step();
    bvalid = 1'b0;
    chk("sw_one_b", b_cnt - b0, 32'd1);
    finish_rsp();

    // lw with SLVERR, response stalled, next request waiting
    issue(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'd0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = 2'd2;
    step();
    rvalid = 1'b0; rresp = 2'd0;
    req_we = 1'b0; req_addr = 32'h8000_0008;
    req_size = 2'd2; req_sign = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("err_flag", {31'd0, rsp_err}, 32'd1);
      chk("err_rdata", rsp_rdata, 32'h0BAD_F00D);
      chk("err_no_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("err_rsp_done", {31'd0, rsp_valid}, 32'd0);
    chk("err_no_same_cycle", {31'd0, arvalid}, 32'd0);
    chk("err_idle", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    chk("lw2_arvalid", {31'd0, arvalid}, 32'd1);
    chk("lw2_araddr", araddr, 32'h8000_0008);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("lw2_rready", {31'd0, rready}, 32'd1);

    // reset in RD_DATA
    rst_n = 1'b0;
    #1;
    chk("arst_rready", {31'd0, rready}, 32'd0);
    chk("arst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("arst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("arst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("arst_bready", {31'd0, bready}, 32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_rsp_rdata", rsp_rdata, 32'd0);
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    step();

    // lhu after reset, offset 2
    issue(1'b0, 32'h8000_0006, 2'd1, 1'b0, 32'd0);
    chk("lhu_araddr", araddr, 32'h8000_0004);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h8765_ABCD;
    step();
    rvalid = 1'b0;
    chk("lhu_rdata", rsp_rdata, 32'h0000_8765);
    chk("lhu_err", {31'd0, rsp_err}, 32'd0);
    finish_rsp();

    // sb with DECERR
    issue(1'b1, 32'h8000_0001, 2'd0, 1'b0, 32'h0000_00A5);
    chk("sb_wstrb", {28'd0, wstrb}, 32'h2);
    chk("sb_wdata", wdata, 32'h0000_A500);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'd3;
    step();
    bvalid = 1'b0; bresp = 2'd0;
    chk("sb_err", {31'd0, rsp_err}, 32'd1);
    chk("sb_rdata", rsp_rdata, 32'd0);
    finish_rsp();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
